// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: two in-order result queues (ALU, load) drained
// round-robin onto one registered register-file write port.
module wb_port_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [31:0] alu_data,
    input  logic [4:0]  alu_dest,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_data,
    input  logic [4:0]  ld_dest,
    output logic        write_enable,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data,
    output logic [31:0] pending_mask
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic REQ_ALU = 1'b0;

    logic [31:0]   data_mem_q [2][DEPTH];
    logic [4:0]    dest_mem_q [2][DEPTH];
    logic [AW-1:0] wptr_q [2];
    logic [AW-1:0] wptr_d [2];
    logic [AW-1:0] rptr_q [2];
    logic [AW-1:0] rptr_d [2];
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic          last_grant_q, last_grant_d;
    logic          we_q, we_d;
    logic [4:0]    wreg_q, wreg_d;
    logic [31:0]   wdata_q, wdata_d;

    logic [1:0]    in_valid;
    logic [31:0]   in_data [2];
    logic [4:0]    in_dest [2];
    logic [1:0]    ready, push, pop, nonempty;
    logic          grant, sel;
    logic [31:0]   head_data;
    logic [4:0]    head_dest;
    logic [AW-1:0] off;
    logic [31:0]   mask;

    assign in_valid   = {ld_valid, alu_valid};
    assign in_data[0] = alu_data;
    assign in_data[1] = ld_data;
    assign in_dest[0] = alu_dest;
    assign in_dest[1] = ld_dest;

    // Ready looks only at the current count, never at a same-cycle pop.
    always_comb begin
        ready    = '0;
        push     = '0;
        nonempty = '0;
        for (int r = 0; r < 2; r++) begin
            ready[r]    = (cnt_q[r] < CW'(DEPTH)) && reset && !flush;
            push[r]     = in_valid[r] && ready[r];
            nonempty[r] = (cnt_q[r] != '0);
        end
    end

    assign grant     = (|nonempty) && reset && !flush;
    assign sel       = (&nonempty) ? ~last_grant_q : nonempty[1];
    assign pop       = grant ? (sel ? 2'b10 : 2'b01) : 2'b00;
    assign head_data = data_mem_q[sel][rptr_q[sel]];
    assign head_dest = dest_mem_q[sel][rptr_q[sel]];

    always_comb begin
        for (int r = 0; r < 2; r++) begin
            wptr_d[r] = wptr_q[r] + AW'(push[r]);
            rptr_d[r] = rptr_q[r] + AW'(pop[r]);
            cnt_d[r]  = cnt_q[r] + CW'(push[r]) - CW'(pop[r]);
            if (flush) begin
                wptr_d[r] = '0;
                rptr_d[r] = '0;
                cnt_d[r]  = '0;
            end
        end
        last_grant_d = grant ? sel : last_grant_q;
        we_d         = grant && (head_dest != 5'd0);
        wreg_d       = we_d ? head_dest : 5'd0;
        wdata_d      = we_d ? head_data : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < 2; r++) begin
                wptr_q[r] <= '0;
                rptr_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            last_grant_q <= REQ_ALU;
            we_q         <= 1'b0;
            wreg_q       <= 5'd0;
            wdata_q      <= 32'd0;
        end else begin
            for (int r = 0; r < 2; r++) begin
                wptr_q[r] <= wptr_d[r];
                rptr_q[r] <= rptr_d[r];
                cnt_q[r]  <= cnt_d[r];
            end
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            wreg_q       <= wreg_d;
            wdata_q      <= wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < 2; r++) begin
            if (push[r]) begin
                data_mem_q[r][wptr_q[r]] <= in_data[r];
                dest_mem_q[r][wptr_q[r]] <= in_dest[r];
            end
        end
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        mask = '0;
        off  = '0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                off = AW'(i) - rptr_q[r];
                if ({1'b0, off} < cnt_q[r]) begin
                    mask[dest_mem_q[r][i]] = 1'b1;
                end
            end
        end
        if (we_q) begin
            mask[wreg_q] = 1'b1;
        end
        mask[0] = 1'b0;
        if (!reset) begin
            mask = '0;
        end
    end

    assign alu_ready    = ready[0];
    assign ld_ready     = ready[1];
    assign write_enable = we_q;
    assign write_reg    = wreg_q;
    assign write_data   = wdata_q;
    assign pending_mask = mask;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: queue-based reference model predicts
// every write-port cycle; a negedge monitor pops and compares.
module tb_wb_port_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic        alu_valid, alu_ready;
    logic [31:0] alu_data;
    logic [4:0]  alu_dest;
    logic        ld_valid, ld_ready;
    logic [31:0] ld_data;
    logic [4:0]  ld_dest;
    logic        write_enable;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [31:0] pending_mask;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_data     (alu_data),
        .alu_dest     (alu_dest),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_data      (ld_data),
        .ld_dest      (ld_dest),
        .write_enable (write_enable),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .pending_mask (pending_mask)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  dest;
    } ent_t;

    ent_t aq[$];
    ent_t lq[$];
    ent_t expq[$];
    bit         m_last_ld = 1'b0;
    bit         m_we = 1'b0;
    logic [4:0] m_reg = 5'd0;
    int n_chk = 0;
    int n_fail = 0;
    bit a_acc, l_acc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: per-requester FIFOs and a round-robin preference bit.
    always @(posedge clk) begin : model
        bit   a_rdy, l_rdy, have;
        ent_t g;
        a_rdy = aq.size() < DEPTH;
        l_rdy = lq.size() < DEPTH;
        have  = 1'b1;
        g     = '0;
        if (!reset) begin
            aq.delete();
            lq.delete();
            m_last_ld = 1'b0;
            m_we = 1'b0;
            m_reg = 5'd0;
        end else if (flush) begin
            aq.delete();
            lq.delete();
            m_we = 1'b0;
            m_reg = 5'd0;
        end else begin
            if (aq.size() > 0 && lq.size() > 0) begin
                if (m_last_ld) begin g = aq.pop_front(); m_last_ld = 1'b0; end
                else           begin g = lq.pop_front(); m_last_ld = 1'b1; end
            end else if (aq.size() > 0) begin
                g = aq.pop_front(); m_last_ld = 1'b0;
            end else if (lq.size() > 0) begin
                g = lq.pop_front(); m_last_ld = 1'b1;
            end else begin
                have = 1'b0;
            end
            m_we  = have && (g.dest != 5'd0);
            m_reg = m_we ? g.dest : 5'd0;
            if (m_we) expq.push_back(g);
            if (alu_valid && a_rdy) aq.push_back({alu_data, alu_dest});
            if (ld_valid && l_rdy)  lq.push_back({ld_data, ld_dest});
        end
    end

    always @(negedge clk) begin : monitor
        logic [31:0] em;
        ent_t e;
        em = '0;
        foreach (aq[i]) em[aq[i].dest] = 1'b1;
        foreach (lq[i]) em[lq[i].dest] = 1'b1;
        if (m_we) em[m_reg] = 1'b1;
        em[0] = 1'b0;
        if (!reset) em = '0;
        chk("pending_mask", pending_mask, em);
        chk("alu_ready", 32'(alu_ready), 32'(reset && !flush && aq.size() < DEPTH));
        chk("ld_ready", 32'(ld_ready), 32'(reset && !flush && lq.size() < DEPTH));
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("write_enable", 32'(write_enable), 32'd1);
            chk("write_reg", 32'(write_reg), 32'(e.dest));
            chk("write_data", write_data, e.data);
        end else begin
            chk("write_enable idle", 32'(write_enable), 32'd0);
            chk("write_reg idle", 32'(write_reg), 32'd0);
            chk("write_data idle", write_data, 32'd0);
        end
    end

    task automatic step();
        @(negedge clk);
        a_acc = alu_valid && alu_ready;
        l_acc = ld_valid && ld_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [31:0] ad, input logic [4:0] adst,
                         input logic lv, input logic [31:0] ldd, input logic [4:0] ldst);
        alu_valid = av; alu_data = ad; alu_dest = adst;
        ld_valid  = lv; ld_data  = ldd; ld_dest  = ldst;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 5'd0);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int aidx;
        reset = 1'b0;
        flush = 1'b0;
        idle(2);
        reset = 1'b1;

        drive(1'b1, 32'hDEADBEEF, 5'd5, 1'b0, 32'd0, 5'd0);
        step();
        idle(4);

        drive(1'b1, 32'h11, 5'd1, 1'b1, 32'h22, 5'd2);
        step();
        idle(4);

        aidx = 0;
        for (int c = 0; c < 12; c++) begin
            drive(aidx < 3, 32'hA000_0000 + 32'(aidx), 5'(10 + aidx),
                  1'b1, $urandom, 5'(20 + (c % 8)));
            step();
            if (a_acc) aidx++;
        end
        idle(4);

        drive(1'b0, 32'd0, 5'd0, 1'b1, 32'h55, 5'd0);
        step();
        idle(2);
        drive(1'b1, 32'h66, 5'd3, 1'b1, 32'h77, 5'd4);
        step();
        idle(4);

        drive(1'b1, 32'hB1, 5'd6, 1'b1, 32'hC1, 5'd7);
        step();
        drive(1'b1, 32'hB2, 5'd8, 1'b0, 32'd0, 5'd0);
        step();
        flush = 1'b1;
        drive(1'b1, 32'hBAD0, 5'd9, 1'b1, 32'hBAD1, 5'd11);
        step();
        flush = 1'b0;
        idle(4);

        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 32'hE0 + 32'(c), 5'(12 + c), 1'b1, 32'hF0 + 32'(c), 5'(24 + c));
            step();
        end
        reset = 1'b0;
        step();
        reset = 1'b1;
        drive(1'b1, 32'h1234, 5'd13, 1'b1, 32'h5678, 5'd14);
        step();
        idle(4);

        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) != 0);
            flush = ($urandom_range(0, 49) == 0);
            drive($urandom_range(0, 9) < 6, $urandom, 5'($urandom_range(0, 31)),
                  $urandom_range(0, 9) < 6, $urandom, 5'($urandom_range(0, 31)));
            step();
        end
        reset = 1'b1;
        flush = 1'b0;
        idle(10);

        chk("scoreboard drained", 32'(expq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
